d_row_loader: RTL and testbench
===============================

# d_row_loader

Datapath stage directly downstream of the matrix-D read-address generator and the D scratchpad BRAM. It consumes the BRAM read word together with the generator's one-hot row-activate vector. It realigns both for memory read latency and shifts each word into the selected systolic row's N2-deep staging register. When a row's group of N2 words is complete, it presents the group to the systolic array with a one-cycle load strobe, and raises `done` once the full D stream (M3·N1·M1dN1 words) has been delivered.

## Interface
Parameters:
- `N1`, 4, systolic rows; width of the activate vector.
- `N2`, 4, words per row group; staging register depth.
- `DATA_W`, 8, D element width.
- `MATRIXSIZE_W`, 16, width of the matrix-size inputs.
- `RD_LAT`, 1, BRAM read latency in cycles, counted from the address register to data valid (≥1).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `M3` in MATRIXSIZE_W: D column count; held stable while running.
- `M1dN1` in MATRIXSIZE_W: phase count (M1/N1); held stable while running.
- `valid_D` in 1: the same valid that drives the address generator.
- `activate_D` in N1: the generator's registered one-hot row select.
- `rd_data_D` in DATA_W: BRAM read data.
- `row_data` out N1·N2·DATA_W: per-row parallel groups. Row r occupies bits [(r+1)·N2·DATA_W-1 : r·N2·DATA_W], and slot k sits within row r at offset k·DATA_W.
- `row_load` out N1: one-cycle strobe per row when `row_data` for that row has been updated.
- `done` out 1: sticky once all words have been accepted.

## Operation
- Alignment:
  - `wv` is `valid_D` delayed by 1+RD_LAT cycles. The extra 1 accounts for the generator's address register.
  - `wa` is `activate_D` delayed by RD_LAT cycles.
  - Both delay lines clear to 0 on `rst`.
- Accept condition: `acc = wv && (wa != 0) && !done`. A word arriving while `done` is high is dropped.
- Per row r with `acc && wa[r]`:
  - `sh[r] <= {sh[r][N2-2:0], rd_data_D}` (the newest word enters slot 0).
  - `cnt[r]` increments.
- If more than one bit of `wa` is set, every selected row takes the same word (broadcast). No error is raised.
- Group completion: when a word is accepted with `cnt[r]==N2-1`:
  - `cnt[r]` wraps to 0.
  - On the next edge, `row_data[r]` is set to the completed vector including the new word, and `row_load[r]` is 1 for one cycle.
  - The first word of the group lands in slot N2-1. The generator issues addresses in descending order within a group, so slot k holds element offset k.
- `row_data[r]` holds its value until the next completion for that row.
- Total counter `tot`:
  - Width 2·MATRIXSIZE_W + clog2(N1).
  - Increments once per accepted word, not once per row when broadcast.
  - When an accepted word makes `tot == M3·N1·M1dN1`, `done` is set on that edge and stays set until `rst`.
- Precondition: M3 is a multiple of N2. There is no partial-group flush. Leftover words remain in `sh`/`cnt` and are never loaded.
- M3==0 or M1dN1==0: `done` never asserts and words are still staged. Bench must not rely on this case.

## Timing
- Reset values:
  - `row_data`, `row_load`, `done`: 0.
  - All `sh`, `cnt`, `tot`, and delay-line state: 0.
- Reset mid-stream discards all partial groups and in-flight delayed words. The first word accepted after reset starts a fresh group in every row.
- Latency:
  - `valid_D` high at edge t puts its data word into `sh` at edge t+1+RD_LAT.
  - `row_load` for a completing word is visible after edge t+2+RD_LAT.
- Throughput: one word per cycle, with no backpressure. `row_load` may pulse on consecutive cycles for different rows.
- On the final word, the `done` edge coincides with that word's `sh` update. The final row's `row_load` follows one cycle later, because `done` does not suppress the pending load.
- Gaps in `valid_D` stall staging without losing state.

## Structure
- Shared package `d_loader_pkg`:
  - `typedef logic [DATA_W-1:0] d_word_t`.
  - Function `d_total_words(M3, M1dN1, N1)` returning the `tot` target.
- Sub-module `pipe_delay #(WIDTH, DEPTH)`: a resettable shift-register delay line, instanced twice (valid and activate). DEPTH=0 is a wire.
- Per-row staging is a generate loop in the top module. No further sub-modules.

## Test plan
- N1=4, N2=4, RD_LAT=1, M3=8, M1dN1=2, `rd_data_D`=address model, `valid_D` continuous:
  - 64 words accepted.
  - `row_load` pulses in order r0,r0,r1,r1,r2,r2,r3,r3, twice over.
  - `done` rises on the 64th accepted word.
- Same config, `valid_D` toggled 1-0 every cycle: identical `row_data` sequence and `done` count; only timing is stretched.
- `rst` asserted after 6 words into row 0: all outputs 0. The next 4 words into row 0 produce `row_load[0]` with exactly those 4 values.
- `activate_D`=4'b0101 for 4 words: rows 0 and 2 load identical vectors; `tot` advances by 4.
- Extra `valid_D` cycles after `done`: no `row_load`, `row_data` unchanged.
- RD_LAT=3, 4 words 0x11,0x22,0x33,0x44 into row 1: `row_data[1]` slot3=0x11 … slot0=0x44, with `row_load[1]` exactly 5 cycles after the 4th `valid_D`.

Source files
------------

// File: rtl/d_loader_pkg.sv
// d_loader_pkg: shared types and helpers for the matrix-D row loader.
package d_loader_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] d_word_t;

    // Words in the whole D stream: M3 columns x N1 rows x M1/N1 phases.
    function automatic logic [63:0] d_total_words(
        input logic [31:0] m3,
        input logic [31:0] m1dn1,
        input int          n1
    );
        return 64'(m3) * 64'(m1dn1) * 64'(n1);
    endfunction

endpackage

// File: rtl/d_row_loader_delay.sv
// pipe_delay: resettable shift-register delay line; DEPTH of 0 is a wire.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    import d_loader_pkg::*;

    if (DEPTH == 0) begin : g_wire
        logic unused;
        assign unused = clk ^ rst;
        assign q_o    = d_i;
    end else begin : g_sr
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/d_row_loader.sv
// d_row_loader: realigns D BRAM words with their row select and stages
// them into per-row N2-word groups for the systolic array.
module d_row_loader #(
    parameter int N1           = 4,
    parameter int N2           = 4,
    parameter int DATA_W       = 8,
    parameter int MATRIXSIZE_W = 16,
    parameter int RD_LAT       = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MATRIXSIZE_W-1:0]   M3,
    input  logic [MATRIXSIZE_W-1:0]   M1dN1,
    input  logic                      valid_D,
    input  logic [N1-1:0]             activate_D,
    input  logic [DATA_W-1:0]         rd_data_D,
    output logic [N1*N2*DATA_W-1:0]   row_data,
    output logic [N1-1:0]             row_load,
    output logic                      done
);
    import d_loader_pkg::*;

    localparam int TOT_W = 2*MATRIXSIZE_W + $clog2(N1);
    localparam int CNT_W = (N2 > 1) ? $clog2(N2) : 1;
    localparam int GRP_W = N2*DATA_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N2-1);

    logic             wv;
    logic [N1-1:0]    wa;
    logic             acc;
    logic [TOT_W-1:0] tot_q, tot_d;
    logic             done_q, done_d;
    logic [63:0]      target;

    // Valid also waits out the generator's address register.
    pipe_delay #(.WIDTH(1), .DEPTH(1+RD_LAT)) u_vdly (
        .clk (clk),
        .rst (rst),
        .d_i (valid_D),
        .q_o (wv)
    );

    pipe_delay #(.WIDTH(N1), .DEPTH(RD_LAT)) u_adly (
        .clk (clk),
        .rst (rst),
        .d_i (activate_D),
        .q_o (wa)
    );

    assign acc    = wv && (wa != '0) && !done_q;
    assign target = d_total_words(32'(M3), 32'(M1dN1), N1);

    always_comb begin
        tot_d  = tot_q;
        done_d = done_q;
        if (acc) begin
            tot_d = tot_q + 1'b1;
            if (64'(tot_d) == target) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tot_q  <= '0;
            done_q <= 1'b0;
        end else begin
            tot_q  <= tot_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;

    for (genvar r = 0; r < N1; r++) begin : g_row
        logic [GRP_W-1:0] sh_q, sh_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [GRP_W-1:0] data_q;
        logic             pend_q, load_q;
        logic             take, last;

        assign take = acc && wa[r];
        assign last = (cnt_q == CNT_LAST);

        always_comb begin
            sh_d  = sh_q;
            cnt_d = cnt_q;
            if (take) begin
                sh_d  = {sh_q[GRP_W-DATA_W-1:0], rd_data_D};
                cnt_d = last ? '0 : cnt_q + 1'b1;
            end
        end

        // Completed group is published one edge after its last word.
        always_ff @(posedge clk) begin
            if (rst) begin
                sh_q   <= '0;
                cnt_q  <= '0;
                pend_q <= 1'b0;
                load_q <= 1'b0;
                data_q <= '0;
            end else begin
                sh_q   <= sh_d;
                cnt_q  <= cnt_d;
                pend_q <= take && last;
                load_q <= pend_q;
                if (pend_q) begin
                    data_q <= sh_q;
                end
            end
        end

        assign row_data[r*GRP_W +: GRP_W] = data_q;
        assign row_load[r]                = load_q;
    end

endmodule

// File: tb/tb_d_row_loader.sv
// tb_d_row_loader: directed and random checks of d_row_loader against a
// word-level queue model of row grouping, loading and completion.
module tb_d_row_loader;

    localparam int N1 = 4;
    localparam int N2 = 4;
    localparam int DW = 8;
    localparam int MW = 16;
    localparam int GW = N2*DW;
    localparam int RW = N1*GW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [MW-1:0] M3 = 16'd8;
    logic [MW-1:0] M1dN1 = 16'd2;
    logic          valid_D = 1'b0;
    logic [N1-1:0] activate_D = '0;
    logic [DW-1:0] rd1 = '0;
    logic [DW-1:0] rd3 = '0;
    logic [RW-1:0] row_data1, row_data3;
    logic [N1-1:0] row_load1, row_load3;
    logic          done1, done3;

    always #5 clk = ~clk;

    d_row_loader #(
        .N1(N1), .N2(N2), .DATA_W(DW), .MATRIXSIZE_W(MW), .RD_LAT(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .M3(M3), .M1dN1(M1dN1),
        .valid_D(valid_D), .activate_D(activate_D), .rd_data_D(rd1),
        .row_data(row_data1), .row_load(row_load1), .done(done1)
    );

    d_row_loader #(
        .N1(N1), .N2(N2), .DATA_W(DW), .MATRIXSIZE_W(MW), .RD_LAT(3)
    ) u_dut3 (
        .clk(clk), .rst(rst), .M3(M3), .M1dN1(M1dN1),
        .valid_D(valid_D), .activate_D(activate_D), .rd_data_D(rd3),
        .row_data(row_data3), .row_load(row_load3), .done(done3)
    );

    typedef struct {
        int            due;
        logic [N1-1:0] a;
        logic [DW-1:0] w;
    } iss_t;

    typedef struct {
        int            r;
        logic [GW-1:0] d;
    } ld_t;

    iss_t          iq[$];
    ld_t           lq[$];
    bit            logon = 1'b0;
    int            total = 0;
    int            bad = 0;
    int            ecnt = 0;
    int            tot_m = 0;
    bit            done_m = 1'b0;
    logic [N1-1:0] pend_m = '0;
    logic [N1-1:0] exp_load = '0;
    logic [RW-1:0] exp_data = '0;
    logic [DW-1:0] grp [N1][N2];
    int            gcnt [N1];
    logic [GW-1:0] fin [N1];
    logic [N1-1:0] act_q = '0;
    logic [DW-1:0] dp [4];

    task automatic chk(input string tag, input logic [RW-1:0] obs,
                       input logic [RW-1:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // Word-level reference: a word issued at edge e lands at edge e+2;
    // groups complete after N2 words and are published one edge later.
    task automatic model_step();
        iss_t it;
        exp_load = pend_m;
        for (int r = 0; r < N1; r++) begin
            if (pend_m[r]) exp_data[r*GW +: GW] = fin[r];
        end
        pend_m = '0;
        while (iq.size() > 0 && iq[0].due == ecnt) begin
            it = iq.pop_front();
            if (!done_m && it.a != '0) begin
                tot_m++;
                for (int r = 0; r < N1; r++) begin
                    if (it.a[r]) begin
                        grp[r][gcnt[r]] = it.w;
                        gcnt[r]++;
                        if (gcnt[r] == N2) begin
                            for (int k = 0; k < N2; k++) begin
                                fin[r][k*DW +: DW] = grp[r][N2-1-k];
                            end
                            pend_m[r] = 1'b1;
                            gcnt[r] = 0;
                        end
                    end
                end
                if (tot_m == int'(M3) * N1 * int'(M1dN1)) done_m = 1'b1;
            end
        end
    endtask

    task automatic tick(input logic v, input logic [N1-1:0] a,
                        input logic [DW-1:0] w);
        valid_D = v;
        @(posedge clk);
        ecnt++;
        #1;
        if (v) begin
            act_q = a;
            iq.push_back('{ecnt + 2, a, w});
        end
        activate_D = act_q;
        for (int i = 3; i > 0; i--) dp[i] = dp[i-1];
        dp[0] = v ? w : DW'($urandom);
        rd1 = dp[1];
        rd3 = dp[3];
        model_step();
        chk("row_load", RW'(row_load1), RW'(exp_load));
        chk("row_data", row_data1, exp_data);
        chk("done", RW'(done1), RW'(done_m));
        if (logon) begin
            for (int r = 0; r < N1; r++) begin
                if (row_load1[r]) lq.push_back('{r, row_data1[r*GW +: GW]});
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid_D = 1'b0;
        @(posedge clk);
        ecnt++;
        #1;
        rst = 1'b0;
        iq.delete();
        pend_m = '0;
        exp_load = '0;
        exp_data = '0;
        tot_m = 0;
        done_m = 1'b0;
        for (int r = 0; r < N1; r++) gcnt[r] = 0;
        chk("rst_load", RW'(row_load1), '0);
        chk("rst_data", row_data1, '0);
        chk("rst_done", RW'(done1), '0);
    endtask

    function automatic logic [GW-1:0] grp_exp(input int i);
        logic [GW-1:0] v;
        int p, r, g;
        p = i / 8;
        r = (i % 8) / 2;
        g = i % 2;
        for (int k = 0; k < N2; k++) begin
            v[k*DW +: DW] = DW'((p*N1 + r)*8 + g*4 + k);
        end
        return v;
    endfunction

    task automatic run_stream(input bit gaps);
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < N1; r++)
                for (int g = 0; g < 2; g++)
                    for (int k = N2 - 1; k >= 0; k--) begin
                        tick(1'b1, N1'(1 << r), DW'((p*N1 + r)*8 + g*4 + k));
                        if (gaps) tick(1'b0, '0, '0);
                    end
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_nloads"}, RW'(lq.size()), RW'(16));
        for (int i = 0; i < lq.size() && i < 16; i++) begin
            chk({tag, "_row"}, RW'(lq[i].r), RW'((i % 8) / 2));
            chk({tag, "_grp"}, RW'(lq[i].d), RW'(grp_exp(i)));
        end
    endtask

    initial begin
        logic [N1-1:0] ra;
        for (int i = 0; i < 4; i++) dp[i] = '0;
        for (int r = 0; r < N1; r++) gcnt[r] = 0;
        do_reset();

        // Continuous stream with address-valued data.
        lq.delete();
        logon = 1'b1;
        run_stream(1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, '0, '0);
        logon = 1'b0;
        check_stream("cont");
        chk("cont_done", RW'(done1), RW'(1));

        // Words after done are dropped.
        for (int i = 0; i < 6; i++) tick(1'b1, 4'b0001, DW'($urandom));
        for (int i = 0; i < 3; i++) tick(1'b0, '0, '0);
        chk("post_done_load", RW'(row_load1), '0);

        // Same stream with valid toggling.
        do_reset();
        lq.delete();
        logon = 1'b1;
        run_stream(1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, '0, '0);
        logon = 1'b0;
        check_stream("gap");

        // Reset discards a partially filled row.
        do_reset();
        for (int i = 0; i < 6; i++) tick(1'b1, 4'b0001, DW'(i + 1));
        do_reset();
        lq.delete();
        logon = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b1, 4'b0001, DW'(8'hA0 + i));
        for (int i = 0; i < 3; i++) tick(1'b0, '0, '0);
        logon = 1'b0;
        chk("rst_nloads", RW'(lq.size()), RW'(1));
        if (lq.size() > 0) begin
            chk("rst_row", RW'(lq[0].r), RW'(0));
            chk("rst_grp", RW'(lq[0].d), RW'(32'hA0A1A2A3));
        end

        // Broadcast counts once toward the total.
        do_reset();
        M3 = 16'd4;
        M1dN1 = 16'd1;
        for (int i = 0; i < 4; i++) tick(1'b1, 4'b0101, DW'(8'hB0 + i));
        for (int i = 0; i < 3; i++) tick(1'b0, '0, '0);
        chk("bc_row0", RW'(row_data1[0 +: GW]), RW'(32'hB0B1B2B3));
        chk("bc_row2", RW'(row_data1[2*GW +: GW]), RW'(32'hB0B1B2B3));
        for (int i = 0; i < 12; i++) tick(1'b1, 4'b0010, DW'($urandom));
        tick(1'b0, '0, '0);
        chk("bc_done_early", RW'(done1), RW'(0));
        tick(1'b0, '0, '0);
        chk("bc_done", RW'(done1), RW'(1));

        // Deeper read latency on the second instance.
        do_reset();
        M3 = 16'd8;
        M1dN1 = 16'd2;
        tick(1'b1, 4'b0010, 8'h11);
        tick(1'b1, 4'b0010, 8'h22);
        tick(1'b1, 4'b0010, 8'h33);
        tick(1'b1, 4'b0010, 8'h44);
        for (int k = 1; k <= 6; k++) begin
            tick(1'b0, '0, '0);
            chk("lat3_load", RW'(row_load3[1]), RW'(k == 5));
            if (k == 5) chk("lat3_data", RW'(row_data3[GW +: GW]), RW'(32'h11223344));
        end
        chk("lat3_done", RW'(done3), RW'(0));

        // Random stream against the model.
        do_reset();
        M3 = MW'(4 * $urandom_range(1, 2));
        M1dN1 = MW'($urandom_range(1, 2));
        for (int i = 0; i < 200; i++) begin
            ra = N1'(1 << $urandom_range(0, N1 - 1));
            if ($urandom_range(0, 7) == 0) ra = ra | N1'(1 << $urandom_range(0, N1 - 1));
            tick($urandom_range(0, 9) < 7, ra, DW'($urandom));
        end
        chk("rnd_done", RW'(done1), RW'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
